data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised synchronous data memory with a valid/ready request channel and a valid/ready response channel. It succeeds the fixed 64-word, asynchronous-read, word-only data memory used in processor benches.
- Adds byte and halfword access with byte-lane writes.
- Adds sign/zero-extended loads and configurable read latency.
- Adds response backpressure and misaligned/out-of-range error reporting.
- Sits between a processor memory stage (or bench) and storage.

Parameters:
ADDR_W, 32, byte-address width.
DEPTH_WORDS, 64, number of 32-bit words; power of two, ≥4.
RD_LATENCY, 1, cycles from request acceptance to response valid; 1..4.
RSP_DEPTH, 2, response buffer entries and outstanding-request limit; ≥1. Full throughput requires ≥RD_LATENCY+1.

Ports:
i_clk  in  1  clock, all logic on rising edge.
i_rst  in  1  synchronous reset, active high.
i_req_valid  in  1  request present.
o_req_ready  out  1  request accepted this cycle when valid&ready.
i_req_we  in  1  1=store, 0=load.
i_req_addr  in  ADDR_W  byte address.
i_req_size  in  2  mem_size_t: 0=byte, 1=half, 2=word; 3 is illegal.
i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
i_req_wdata  in  32  store data, right-aligned.
o_rsp_valid  out  1  response at buffer head.
i_rsp_ready  in  1  consumer pops the head when valid&ready.
o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
o_rsp_err  out  1  request was misaligned, out of range, or illegal size.

Behaviour:
- Reset is synchronous and active high. Clock is i_clk, reset is i_rst.
- On reset: o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. The outstanding counter, latency pipeline and response buffer are cleared.
  - In-flight responses are discarded.
  - Storage contents are not reset. Stores accepted before reset remain committed.
- o_req_ready=1 iff outstanding<RSP_DEPTH and not in reset.
  - It depends only on registered state, never combinationally on i_req_valid or i_rsp_ready.
- outstanding_next = outstanding + accept - pop. Simultaneous accept and pop leave it unchanged.
- Every accepted request, load or store, yields exactly one response. Responses are returned in order.
- Responses enter the buffer exactly RD_LATENCY cycles after acceptance.
  - With an empty buffer, o_rsp_valid rises RD_LATENCY cycles after the accept edge.
  - The credit scheme guarantees buffer space, so the pipeline never stalls.
- Error conditions; any one sets o_rsp_err=1 and suppresses the access:
  - size=3.
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
  - word index addr[ADDR_W-1:2] ≥ DEPTH_WORDS.
  - On error: no write occurs and rdata=0.
- Stores commit on the accept edge, little-endian:
  - byte writes lane addr[1:0] with wdata[7:0].
  - half writes lanes {addr[1],0}+1:{addr[1],0} with wdata[15:0].
  - word writes all lanes.
- Loads sample storage on the accept edge, then delay through the pipeline.
  - A store accepted in a later cycle does not alter an earlier load's data.
  - A load accepted after a store observes it (read-after-write in consecutive cycles returns new data).
- Load extension: byte/half are sign-extended from bit 7/15 unless i_req_unsigned. Word loads ignore i_req_unsigned.
- The response head holds stable while o_rsp_valid & !i_rsp_ready.
- A request presented while not ready is held by the requester and is not sampled.

Decomposition:
- mem_pkg holds:
  - typedef enum mem_size_t {MEM_B, MEM_H, MEM_W}.
  - function lane_mask(size, addr[1:0]) returning 4-bit byte enables.
  - function load_extend(word, size, addr[1:0], unsigned) returning 32 bits.
  - typedef struct mem_rsp_t {rdata, err}.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH) implements the response buffer. It is reused elsewhere.

Test Plan:
- Reset with RD_LATENCY=1, then store word 0xfeedbeef @0x0 and load word @0x0 on the next cycle.
  - Required: two responses; the second has rdata=0xfeedbeef, err=0, and is valid 1 cycle after its accept.
- Store byte 0xAA @0x5, then load byte signed @0x5 and load byte unsigned @0x5.
  - Required: rdata 0xFFFFFFAA then 0x000000AA.
  - Required: word load @0x4 has bits [15:8]=0xAA with the other lanes unchanged.
- Store word 0x12345678 @0x8, then load half signed @0xA → 0x00001234. Load half @0x9 → err=1, rdata=0.
- Store word @ (DEPTH_WORDS*4) → err=1. A subsequent load @0x0 is unchanged. Size=3 → err=1.
- RD_LATENCY=2, RSP_DEPTH=2, i_rsp_ready held 0, issue 4 back-to-back loads.
  - Required: only 2 accepted and o_req_ready=0.
  - Required: after raising i_rsp_ready, all 4 responses arrive in order with correct data.
- Issue 2 loads, assert i_rst for 1 cycle mid-flight.
  - Required: no responses emerge, outstanding=0, o_req_ready=1 the cycle after reset deasserts, and earlier stores persist.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and byte-lane helpers for the data memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  // Per-request context carried alongside the registered read word.
  typedef struct packed {
    logic       err;
    logic       we;
    logic [1:0] size;
    logic [1:0] lane;
    logic       uns;
  } mem_meta_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      MEM_B:   mask = 4'b0001 << addr;
      MEM_H:   mask = addr[1] ? 4'b1100 : 4'b0011;
      MEM_W:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] addr, input logic is_unsigned);
    logic [31:0] shifted;
    logic [31:0] ext;
    shifted = word >> {addr, 3'b000};
    case (size)
      MEM_B:   ext = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   ext = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = word;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; head word is visible while not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_wr, do_rd;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && ((count_reg != CNT_W'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_rd) rd_ptr_reg <= bump(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Synchronous byte-addressable data memory with credit-limited requests, a fixed-latency
// read pipeline and an in-order response buffer.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int RD_LATENCY  = 1,
  parameter int RSP_DEPTH   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [31:0]           mem [DEPTH_WORDS];
  logic [CNT_W-1:0]      outstanding_reg, outstanding_next;
  logic                  accept, pop, push, req_err, fifo_empty;
  logic [IDX_W-1:0]      idx;
  logic [ADDR_W-1:0]     hi_bits;
  logic [3:0]            wr_mask;
  logic [31:0]           wr_lanes;
  logic [RD_LATENCY-1:0] stage_valid_reg;
  mem_meta_t             meta_reg [RD_LATENCY];
  logic [31:0]           word_reg [RD_LATENCY];
  mem_meta_t             tail_meta;
  mem_rsp_t              rsp_in, rsp_head;

  assign idx     = i_req_addr[IDX_W+1:2];
  assign hi_bits = i_req_addr >> (IDX_W + 2);

  // Ready is a pure function of the credit counter, so it never loops back through valid/ready.
  always_comb begin
    o_req_ready = !i_rst && (outstanding_reg < CNT_W'(RSP_DEPTH));
    accept      = i_req_valid && o_req_ready;
    pop         = o_rsp_valid && i_rsp_ready;
    req_err     = (i_req_size == 2'd3)
               || ((i_req_size == MEM_H) && i_req_addr[0])
               || ((i_req_size == MEM_W) && (i_req_addr[1:0] != 2'b00))
               || (hi_bits != '0);
    wr_mask     = (accept && i_req_we && !req_err) ? lane_mask(i_req_size, i_req_addr[1:0]) : 4'b0000;
    case (i_req_size)
      MEM_B:   wr_lanes = {4{i_req_wdata[7:0]}};
      MEM_H:   wr_lanes = {2{i_req_wdata[15:0]}};
      default: wr_lanes = i_req_wdata;
    endcase
    outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(pop);
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_mask[b]) mem[idx][b*8 +: 8] <= wr_lanes[b*8 +: 8];
    end
  end

  // Stage 0 holds the registered storage read; later stages only delay it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_valid_reg <= '0;
    end else begin
      stage_valid_reg[0] <= accept;
      for (int s = 1; s < RD_LATENCY; s++) stage_valid_reg[s] <= stage_valid_reg[s-1];
    end
    if (accept) begin
      meta_reg[0] <= '{err: req_err, we: i_req_we, size: i_req_size,
                       lane: i_req_addr[1:0], uns: i_req_unsigned};
      word_reg[0] <= mem[idx];
    end
    for (int s = 1; s < RD_LATENCY; s++) begin
      meta_reg[s] <= meta_reg[s-1];
      word_reg[s] <= word_reg[s-1];
    end
  end

  assign tail_meta = meta_reg[RD_LATENCY-1];
  assign push      = stage_valid_reg[RD_LATENCY-1];

  always_comb begin
    rsp_in.err   = tail_meta.err;
    rsp_in.rdata = (tail_meta.err || tail_meta.we) ? 32'h0
                 : load_extend(word_reg[RD_LATENCY-1], tail_meta.size, tail_meta.lane, tail_meta.uns);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) outstanding_reg <= '0;
    else       outstanding_reg <= outstanding_next;
  end

  sync_fifo #(
    .WIDTH($bits(mem_rsp_t)),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk    (i_clk),
    .srst   (i_rst),
    .wr_en  (push),
    .wr_data(rsp_in),
    .rd_en  (pop),
    .rd_data(rsp_head),
    .empty  (fifo_empty)
  );

  assign o_rsp_valid = !fifo_empty;
  assign o_rsp_rdata = o_rsp_valid ? rsp_head.rdata : 32'h0;
  assign o_rsp_err   = o_rsp_valid && rsp_head.err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (latency 1 and 2) checked against a byte-level memory model.
module tb_data_mem_ctrl;
  localparam int NW = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_edge;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, req_valid, req_ready, req_we, req_uns;
  logic [1:0]       rsp_valid, rsp_ready, rsp_err, hold_lo, bp_rnd;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][1:0]  req_size;
  logic             bp_mode = 1'b0;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rsp [2] = '{0, 0};
  int          last_pop [2] = '{0, 0};
  logic [1:0]  head_seen = 2'b00;
  exp_t        exp_q [2][$];
  logic [31:0] mdl_mem [2][NW];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    bp_rnd = 2'($urandom);
  end
  assign rsp_ready = ~hold_lo & ({2{~bp_mode}} | bp_rnd);

  data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(NW), .RD_LATENCY(1), .RSP_DEPTH(2)) dut_l1 (
    .i_clk(clk), .i_rst(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_addr(req_addr[0]), .i_req_size(req_size[0]),
    .i_req_unsigned(req_uns[0]), .i_req_wdata(req_wdata[0]), .o_rsp_valid(rsp_valid[0]),
    .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));

  data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(NW), .RD_LATENCY(2), .RSP_DEPTH(2)) dut_l2 (
    .i_clk(clk), .i_rst(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_addr(req_addr[1]), .i_req_size(req_size[1]),
    .i_req_unsigned(req_uns[1]), .i_req_wdata(req_wdata[1]), .o_rsp_valid(rsp_valid[1]),
    .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: memory as an array of words manipulated byte by byte.
  function automatic void model(input int d, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    int nb, w, o;
    logic [31:0] v;
    nb    = 1 << size;
    err   = (size == 2'd3) || ((addr % nb) != 0) || (addr >= NW * 4);
    rdata = 32'h0;
    if (err) return;
    w = int'(addr / 4);
    o = int'(addr % 4);
    if (we) begin
      for (int k = 0; k < nb; k++) mdl_mem[d][w][8*(o+k) +: 8] = wdata[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = mdl_mem[d][w][8*(o+k) +: 8];
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      rdata = v;
    end
  endfunction

  // Monitor at the falling edge: decides what the next rising edge accepts and pops.
  always @(negedge clk) begin
    exp_t e;
    int   rise;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        exp_q[d].delete();
        head_seen[d] = 1'b0;
      end else begin
        if (rsp_valid[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("spurious_rsp", 32'(rsp_valid[d]), 32'h0);
          end else begin
            if (!head_seen[d]) begin
              rise = exp_q[d][0].acc_edge + lat(d);
              if (last_pop[d] > rise) rise = last_pop[d];
              chk("rsp_latency", 32'(cyc), 32'(rise));
              head_seen[d] = 1'b1;
            end
            if (rsp_ready[d]) begin
              e = exp_q[d].pop_front();
              $display("dut%0d rsp %0d: rdata=%08h err=%0b model=%08h/%0b",
                       d, n_rsp[d], rsp_rdata[d], rsp_err[d], e.rdata, e.err);
              n_rsp[d]++;
              chk("rsp_rdata", rsp_rdata[d], e.rdata);
              chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
              last_pop[d]  = cyc + 1;
              head_seen[d] = 1'b0;
            end
          end
        end
        if (req_valid[d] && req_ready[d]) begin
          model(d, req_we[d], req_addr[d], req_size[d], req_uns[d], req_wdata[d], e.rdata, e.err);
          e.acc_edge = cyc + 1;
          exp_q[d].push_back(e);
        end
      end
    end
  end

  // Called and returns just after a rising edge.
  task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_we[d] = we; req_addr[d] = addr; req_size[d] = size;
    req_uns[d] = uns; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        return;
      end
    end
    chk("req_timeout", 32'h1, 32'h0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 300; i++) begin
      if (exp_q[d].size() == 0) return;
      idle(1);
    end
    chk("drain_timeout", 32'(exp_q[d].size()), 32'h0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_acc;
    logic        acc;
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;

    rst = 2'b11; req_valid = '0; req_we = '0; req_uns = '0; hold_lo = '0;
    req_addr = '0; req_wdata = '0; req_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ready_in_reset", 32'(req_ready[d]), 32'h0);
    @(posedge clk); #1;
    rst = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 32'(rsp_valid[d]), 32'h0);
      chk("reset_rdata", rsp_rdata[d], 32'h0);
      chk("reset_err", 32'(rsp_err[d]), 32'h0);
      chk("reset_ready", 32'(req_ready[d]), 32'h1);
    end
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < NW; w++) issue(d, 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom);
      drain(d);
    end

    // Store then load back-to-back, sub-word accesses, errors (latency-1 instance).
    issue(0, 1'b1, 32'h0, 2'd2, 1'b0, 32'hfeedbeef);
    issue(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    issue(0, 1'b1, 32'h5, 2'd0, 1'b0, 32'h000000AA);
    issue(0, 1'b0, 32'h5, 2'd0, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h5, 2'd0, 1'b1, 32'h0);
    issue(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
    issue(0, 1'b1, 32'h8, 2'd2, 1'b0, 32'h12345678);
    issue(0, 1'b0, 32'hA, 2'd1, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h9, 2'd1, 1'b0, 32'h0);
    issue(0, 1'b1, 32'(NW * 4), 2'd2, 1'b0, 32'h0BADF00D);
    issue(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h0, 2'd3, 1'b0, 32'h0);
    issue(0, 1'b1, 32'h2, 2'd3, 1'b0, 32'h55555555);
    issue(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    drain(0);

    // Credit limit with the consumer stalled (latency-2 instance).
    hold_lo[1] = 1'b1;
    req_we[1] = 1'b0; req_size[1] = 2'd2; req_uns[1] = 1'b0; req_addr[1] = 32'h0;
    req_valid[1] = 1'b1; n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); acc = req_ready[1];
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 4) req_valid[1] = 1'b0; else req_addr[1] = 32'(n_acc * 4);
      end
    end
    chk("bp_accepted", 32'(n_acc), 32'd2);
    chk("bp_ready_low", 32'(req_ready[1]), 32'h0);
    chk("bp_rsp_held", 32'(rsp_valid[1]), 32'h1);
    hold_lo[1] = 1'b0;
    for (int i = 0; i < 50 && n_acc < 4; i++) begin
      @(negedge clk); acc = req_ready[1];
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 4) req_valid[1] = 1'b0; else req_addr[1] = 32'(n_acc * 4);
      end
    end
    req_valid[1] = 1'b0;
    chk("bp_all_accepted", 32'(n_acc), 32'd4);
    drain(1);

    // Reset with two loads in flight; the earlier store must survive.
    issue(1, 1'b1, 32'h10, 2'd2, 1'b0, 32'hCAFEF00D);
    drain(1);
    issue(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    issue(1, 1'b0, 32'h14, 2'd2, 1'b0, 32'h0);
    rst[1] = 1'b1;
    idle(1);
    rst[1] = 1'b0;
    @(negedge clk);
    chk("postrst_valid", 32'(rsp_valid[1]), 32'h0);
    chk("postrst_ready", 32'(req_ready[1]), 32'h1);
    idle(5);
    @(negedge clk);
    chk("postrst_no_rsp", 32'(rsp_valid[1]), 32'h0);
    idle(1);
    issue(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    issue(1, 1'b0, 32'h12, 2'd1, 1'b1, 32'h0);
    drain(1);

    // Randomised traffic with random response backpressure.
    bp_mode = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        r  = $urandom_range(0, 9);
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        r  = $urandom_range(0, 19);
        if (r == 0)      a = $urandom;
        else if (r < 3)  a = 32'($urandom_range(NW * 4, NW * 4 + 63));
        else             a = 32'($urandom_range(0, NW * 4 - 1));
        if (($urandom_range(0, 3) != 0) && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
        issue(d, 1'($urandom), a, sz, 1'($urandom), $urandom);
        idle($urandom_range(0, 1));
      end
      bp_mode = 1'b0;
      drain(d);
      bp_mode = 1'b1;
    end
    bp_mode = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
